// File: rtl/fir_run_sched_pkg.sv
// Shared types and constants for the FIR run scheduler.
// State encoding, GPIO mark values and parameter defaults live here.
package fir_run_sched_pkg;

    localparam int DW_DEF         = 32;
    localparam int LEN_W_DEF      = 12;
    localparam int FIFO_DEPTH_DEF = 4;

    localparam logic [7:0] MARK_IDLE  = 8'h00;
    localparam logic [7:0] MARK_START = 8'hA5;
    localparam logic [7:0] MARK_END   = 8'h5A;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KICK,
        ST_STREAM,
        ST_DRAIN,
        ST_DONE
    } state_t;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/fir_run_fifo.sv
// Synchronous first-word-fall-through FIFO with registered storage.
// A pop on an empty FIFO is ignored; a push when full is taken only with a pop.
module fir_run_fifo #(
    parameter int DW    = 32,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] head,
    output logic          full,
    output logic          empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fir_run_sched.sv
// Run scheduler: kicks the FIR, streams X with tlast, collects Y,
// checks Y framing, times the run and drives the start/end GPIO mark.
module fir_run_sched
    import fir_run_sched_pkg::*;
#(
    parameter int DW         = DW_DEF,
    parameter int LEN_W      = LEN_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic             axis_clk,
    input  logic             axis_rst_n,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cmd_start,
    input  logic             x_wr_valid,
    output logic             x_wr_ready,
    input  logic [DW-1:0]    x_wr_data,
    output logic             y_rd_valid,
    input  logic             y_rd_ready,
    output logic [DW-1:0]    y_rd_data,
    output logic             ss_tvalid,
    input  logic             ss_tready,
    output logic [DW-1:0]    ss_tdata,
    output logic             ss_tlast,
    input  logic             sm_tvalid,
    output logic             sm_tready,
    input  logic [DW-1:0]    sm_tdata,
    input  logic             sm_tlast,
    output logic             fir_ap_start,
    input  logic             fir_ap_idle,
    input  logic             fir_ap_done,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [31:0]      cycle_cnt,
    output logic [7:0]       mark
);

    state_t           state;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] len_m1;
    logic [LEN_W-1:0] x_sent;
    logic [LEN_W-1:0] y_recv;
    logic [LEN_W-1:0] y_recv_nx;
    logic             done_seen;

    logic             x_full;
    logic             x_empty;
    logic [DW-1:0]    x_head;
    logic             x_push;
    logic             x_pop;

    logic             y_full;
    logic             y_empty;
    logic             y_push;

    logic             y_phase;
    logic             sm_hs;
    logic             y_in_run;
    logic             y_last;
    logic             frame_err;
    logic             drain_exit;

    assign len_m1     = len - LEN_W'(1);
    assign busy       = (state != ST_IDLE);

    assign x_wr_ready = !x_full;
    assign x_push     = x_wr_valid && !x_full;
    assign ss_tvalid  = (state == ST_STREAM) && !x_empty;
    assign ss_tdata   = x_head;
    assign ss_tlast   = (state == ST_STREAM) && (x_sent == len_m1);
    assign x_pop      = ss_tvalid && ss_tready;

    // Y beats past the run length are still accepted so the FIR never stalls.
    assign y_phase    = (state == ST_STREAM) || (state == ST_DRAIN);
    assign sm_tready  = y_phase && !y_full;
    assign sm_hs      = sm_tvalid && sm_tready;
    assign y_in_run   = (y_recv != len);
    assign y_last     = (y_recv == len_m1);
    assign y_push     = sm_hs && y_in_run;
    assign frame_err  = sm_hs && (!y_in_run || (sm_tlast != y_last));
    assign y_recv_nx  = y_recv + LEN_W'(y_push);
    assign drain_exit = (y_recv_nx == len) && (done_seen || fir_ap_done);

    assign y_rd_valid = !y_empty;

    fir_run_fifo #(
        .DW    (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_xfifo (
        .clk       (axis_clk),
        .rst_n     (axis_rst_n),
        .push      (x_push),
        .push_data (x_wr_data),
        .pop       (x_pop),
        .head      (x_head),
        .full      (x_full),
        .empty     (x_empty)
    );

    fir_run_fifo #(
        .DW    (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_yfifo (
        .clk       (axis_clk),
        .rst_n     (axis_rst_n),
        .push      (y_push),
        .push_data (sm_tdata),
        .pop       (y_rd_ready),
        .head      (y_rd_data),
        .full      (y_full),
        .empty     (y_empty)
    );

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            state        <= ST_IDLE;
            len          <= '0;
            x_sent       <= '0;
            y_recv       <= '0;
            done_seen    <= 1'b0;
            fir_ap_start <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            cycle_cnt    <= '0;
            mark         <= MARK_IDLE;
        end else begin
            fir_ap_start <= 1'b0;
            if (busy) begin
                cycle_cnt <= sat_inc32(cycle_cnt);
            end
            if (busy && fir_ap_done) begin
                done_seen <= 1'b1;
            end
            if (x_pop) begin
                x_sent <= x_sent + LEN_W'(1);
            end
            if (y_push) begin
                y_recv <= y_recv_nx;
            end
            if (frame_err) begin
                err <= 1'b1;
            end
            unique case (state)
                ST_IDLE: begin
                    if (cmd_start && (cfg_len == '0)) begin
                        err <= 1'b1;
                    end else if (cmd_start && fir_ap_idle) begin
                        len          <= cfg_len;
                        done         <= 1'b0;
                        err          <= 1'b0;
                        cycle_cnt    <= '0;
                        fir_ap_start <= 1'b1;
                        state        <= ST_KICK;
                    end
                end
                ST_KICK: begin
                    mark      <= MARK_START;
                    x_sent    <= '0;
                    y_recv    <= '0;
                    done_seen <= fir_ap_done;
                    state     <= ST_STREAM;
                end
                ST_STREAM: begin
                    if (x_pop && ss_tlast) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (drain_exit) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    mark  <= MARK_END;
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_run_sched.sv
// Randomized bench for fir_run_sched with an echoing FIR model,
// an X/Y scoreboard and run-timing checks.
module tb_fir_run_sched;
    import fir_run_sched_pkg::*;

    localparam int DW    = 32;
    localparam int LEN_W = 12;
    localparam logic [31:0] KEY = 32'h5A5A_0F0F;

    logic             axis_clk = 1'b0;
    logic             axis_rst_n = 1'b0;
    logic [LEN_W-1:0] cfg_len = '0;
    logic             cmd_start = 1'b0;
    logic             x_wr_valid = 1'b0;
    logic             x_wr_ready;
    logic [DW-1:0]    x_wr_data = '0;
    logic             y_rd_valid;
    logic             y_rd_ready = 1'b0;
    logic [DW-1:0]    y_rd_data;
    logic             ss_tvalid;
    logic             ss_tready = 1'b0;
    logic [DW-1:0]    ss_tdata;
    logic             ss_tlast;
    logic             sm_tvalid = 1'b0;
    logic             sm_tready;
    logic [DW-1:0]    sm_tdata = '0;
    logic             sm_tlast = 1'b0;
    logic             fir_ap_start;
    logic             fir_ap_idle = 1'b1;
    logic             fir_ap_done = 1'b0;
    logic             busy;
    logic             done;
    logic             err;
    logic [31:0]      cycle_cnt;
    logic [7:0]       mark;

    int errors = 0;
    int checks = 0;

    int cyc = 0;
    int cur_len = 0;
    int tlast_at = 0;
    int dly = 0;
    bit extra_mode = 0;
    bit extra_pending = 0;
    bit sending_extra = 0;
    bit hold_pop = 0;
    bit pop_all = 0;
    int x_to_send = 0;
    int recv = 0;
    int idx = 0;
    int dcnt = -1;
    int k_cyc = 0;
    int lasty_cyc = -1;
    int d_cyc = -1;
    bit mono_bad = 0;
    logic [31:0] prev_cnt = '0;
    logic [31:0] x_model[$];
    logic [31:0] y_exp[$];
    logic [31:0] fir_q[$];

    always #5 axis_clk = ~axis_clk;

    fir_run_sched dut (
        .axis_clk     (axis_clk),
        .axis_rst_n   (axis_rst_n),
        .cfg_len      (cfg_len),
        .cmd_start    (cmd_start),
        .x_wr_valid   (x_wr_valid),
        .x_wr_ready   (x_wr_ready),
        .x_wr_data    (x_wr_data),
        .y_rd_valid   (y_rd_valid),
        .y_rd_ready   (y_rd_ready),
        .y_rd_data    (y_rd_data),
        .ss_tvalid    (ss_tvalid),
        .ss_tready    (ss_tready),
        .ss_tdata     (ss_tdata),
        .ss_tlast     (ss_tlast),
        .sm_tvalid    (sm_tvalid),
        .sm_tready    (sm_tready),
        .sm_tdata     (sm_tdata),
        .sm_tlast     (sm_tlast),
        .fir_ap_start (fir_ap_start),
        .fir_ap_idle  (fir_ap_idle),
        .fir_ap_done  (fir_ap_done),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .cycle_cnt    (cycle_cnt),
        .mark         (mark)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Firmware X feeder, FIR echo model, Y popper and scoreboard monitor.
    initial begin
        logic [31:0] e;
        bit fd;
        forever begin
            @(negedge axis_clk);
            if (axis_rst_n) begin
                if (fir_ap_start) begin
                    k_cyc = cyc; idx = 0; recv = 0; dcnt = -1;
                    lasty_cyc = -1; d_cyc = -1;
                    extra_pending = 0; sending_extra = 0;
                end
                if (x_wr_valid && x_wr_ready) begin
                    x_model.push_back(x_wr_data);
                    y_exp.push_back(x_wr_data ^ KEY);
                    x_to_send--;
                end
                if (ss_tvalid && ss_tready) begin
                    e = (x_model.size() > 0) ? x_model.pop_front() : ~ss_tdata;
                    chk("ss_tdata", 64'(ss_tdata), 64'(e));
                    chk("ss_tlast", 64'(ss_tlast), 64'(recv == cur_len - 1));
                    fir_q.push_back(ss_tdata);
                    recv++;
                end
                if (sm_tvalid && sm_tready) begin
                    if (sending_extra) begin
                        sending_extra = 0;
                    end else begin
                        e = fir_q.pop_front();
                        if (idx == cur_len - 1) begin
                            lasty_cyc = cyc;
                            dcnt = dly;
                            if (extra_mode) extra_pending = 1;
                        end
                        idx++;
                    end
                end
                if (fir_ap_done) d_cyc = cyc;
                if (y_rd_valid && y_rd_ready) begin
                    e = (y_exp.size() > 0) ? y_exp.pop_front() : ~y_rd_data;
                    chk("y_rd_data", 64'(y_rd_data), 64'(e));
                end
                if (busy) begin
                    if (cycle_cnt < prev_cnt) mono_bad = 1;
                    prev_cnt = cycle_cnt;
                end else begin
                    prev_cnt = '0;
                end
            end
            @(posedge axis_clk);
            cyc++;
            #1;
            if (axis_rst_n) begin
                ss_tready = ($urandom_range(3) != 0);
                y_rd_ready = hold_pop ? 1'b0 : (pop_all ? 1'b1 : ($urandom_range(3) != 0));
                x_wr_valid = (x_to_send > 0) && ($urandom_range(3) != 0);
                x_wr_data = $urandom;
                if (extra_pending) begin
                    extra_pending = 0;
                    sending_extra = 1;
                end
                if (sending_extra) begin
                    sm_tvalid = 1; sm_tdata = 32'hBAD0_BAD0; sm_tlast = 1;
                end else if (idx < cur_len && fir_q.size() > 0) begin
                    sm_tvalid = 1;
                    sm_tdata = fir_q[0] ^ KEY;
                    sm_tlast = (idx == tlast_at);
                end else begin
                    sm_tvalid = 0; sm_tlast = 0;
                end
                fd = 0;
                if (dcnt > 0) begin
                    dcnt--;
                    if (dcnt == 0) fd = 1;
                end
                if (dly == 0 && sm_tvalid && !sending_extra && idx == cur_len - 1) fd = 1;
                fir_ap_done = fd;
            end else begin
                ss_tready = 0; y_rd_ready = 0; x_wr_valid = 0;
                sm_tvalid = 0; sm_tlast = 0; fir_ap_done = 0;
            end
        end
    end

    task automatic issue_start(input int l);
        @(posedge axis_clk); #2;
        cfg_len = LEN_W'(l);
        cmd_start = 1;
        @(posedge axis_clk); #2;
        cmd_start = 0;
    endtask

    task automatic run(input int l, input int tl, input int d, input bit ex,
                       input int pre, input bit dup, input bit exp_err);
        int n;
        int mx;
        cur_len = l; tlast_at = tl; dly = d; extra_mode = ex;
        if (pre > 0) begin
            x_to_send += pre;
            n = 0;
            while (x_to_send > 0 && n < 1000) begin
                @(negedge axis_clk); n++;
            end
            @(negedge axis_clk);
        end
        x_to_send += l - pre;
        issue_start(l);
        @(negedge axis_clk);
        chk("ap_start_kick", 64'(fir_ap_start), 64'(1));
        chk("busy_kick", 64'(busy), 64'(1));
        @(negedge axis_clk);
        chk("ap_start_once", 64'(fir_ap_start), 64'(0));
        chk("mark_start", 64'(mark), 64'(MARK_START));
        chk("err_cleared", 64'(err), 64'(0));
        chk("done_cleared", 64'(done), 64'(0));
        if (dup) issue_start(3);
        n = 0;
        while (!done && n < 3000) begin
            @(negedge axis_clk); n++;
        end
        chk("run_done", 64'(done), 64'(1));
        mx = (lasty_cyc > d_cyc) ? lasty_cyc : d_cyc;
        chk("done_cycle", 64'(cyc), 64'(mx + 2));
        chk("cycle_cnt", 64'(cycle_cnt), 64'(mx - k_cyc + 2));
        chk("mark_end", 64'(mark), 64'(MARK_END));
        chk("busy_end", 64'(busy), 64'(0));
        chk("err_end", 64'(err), 64'(exp_err));
        n = 0;
        while ((y_exp.size() > 0 || x_to_send > 0) && n < 3000) begin
            @(negedge axis_clk); n++;
        end
        chk("y_drained", 64'(y_exp.size()), 64'(0));
        chk("x_consumed", 64'(x_model.size()), 64'(0));
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'(0));
        chk({tag, "_done"}, 64'(done), 64'(0));
        chk({tag, "_err"}, 64'(err), 64'(0));
        chk({tag, "_mark"}, 64'(mark), 64'(MARK_IDLE));
        chk({tag, "_cnt"}, 64'(cycle_cnt), 64'(0));
        chk({tag, "_start"}, 64'(fir_ap_start), 64'(0));
        chk({tag, "_ssv"}, 64'(ss_tvalid), 64'(0));
        chk({tag, "_yv"}, 64'(y_rd_valid), 64'(0));
        chk({tag, "_smr"}, 64'(sm_tready), 64'(0));
        chk({tag, "_xr"}, 64'(x_wr_ready), 64'(1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        repeat (2) @(negedge axis_clk);
        chk_reset_state("por");
        @(posedge axis_clk); #2;
        axis_rst_n = 1;

        run(4, 3, 2, 0, 4, 0, 0);

        fork
            run(64, 63, 1, 0, 0, 0, 0);
            begin
                n = 0;
                while (idx < 10 && n < 3000) begin
                    @(negedge axis_clk); n++;
                end
                hold_pop = 1;
                repeat (20) @(negedge axis_clk);
                chk("hold_sm_tready", 64'(sm_tready), 64'(0));
                chk("hold_y_valid", 64'(y_rd_valid), 64'(1));
                hold_pop = 0;
            end
        join
        chk("cnt_monotone", 64'(mono_bad), 64'(0));

        run(5, 2, 0, 0, 0, 0, 1);
        run(5, 4, 3, 0, 0, 1, 0);

        issue_start(0);
        @(negedge axis_clk);
        chk("len0_err", 64'(err), 64'(1));
        chk("len0_start", 64'(fir_ap_start), 64'(0));
        chk("len0_busy", 64'(busy), 64'(0));

        fir_ap_idle = 0;
        issue_start(4);
        @(negedge axis_clk);
        chk("notidle_start", 64'(fir_ap_start), 64'(0));
        chk("notidle_busy", 64'(busy), 64'(0));
        fir_ap_idle = 1;

        run(6, 5, 5, 0, 0, 0, 0);
        run(6, 5, 0, 0, 0, 0, 0);

        pop_all = 1;
        run(4, 3, 15, 1, 0, 0, 1);
        pop_all = 0;

        cur_len = 8; tlast_at = 7; dly = 2; extra_mode = 0;
        x_to_send = 8;
        issue_start(8);
        n = 0;
        while (recv < 2 && n < 3000) begin
            @(negedge axis_clk); n++;
        end
        chk("rst_reach_stream", 64'(busy), 64'(1));
        @(posedge axis_clk); #2;
        axis_rst_n = 0;
        x_to_send = 0; cur_len = 0; idx = 0; recv = 0; dcnt = -1;
        extra_pending = 0; sending_extra = 0;
        x_model.delete(); y_exp.delete(); fir_q.delete();
        x_wr_valid = 0; sm_tvalid = 0; sm_tlast = 0; fir_ap_done = 0;
        @(negedge axis_clk);
        chk_reset_state("midrst");
        @(posedge axis_clk); #2;
        axis_rst_n = 1;

        run(8, 7, 1, 0, 0, 0, 0);

        repeat (4) @(negedge axis_clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
